// File: rtl/recirc_pkg.sv
// Shared definitions for the multi-lane recirculator: FSM state encoding and
// a constant-evaluable ceil(log2) helper used to size pointers and counters.
package recirc_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/recirc_lane_fifo.sv
// One lane's active-path FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module recirc_lane_fifo
    import recirc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             empty_next,
    output logic             overflow
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             rd_s, wr_s;

    // Full/empty decode, push/pop qualification and next pointer/storage values.
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        rd_s  = pop & ~empty;
        // A pop on a full FIFO frees the slot the incoming word overwrites.
        wr_s  = push & (~full | rd_s);
        mem_d = mem_q;
        if (wr_s) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        if (push & ~wr_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        empty_next = (wptr_d == rptr_d);
        if (empty) begin
            head = {WIDTH{1'b0}};
        end else begin
            head = mem_q[rptr_q[AW-1:0]];
        end
        overflow = ovf_q;
    end

    // Pointer and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/recirculador_multilane.sv
// Multi-lane recirculator: routes valid words to per-lane active FIFOs while the
// link is active, otherwise to registered recirculation outputs, and sequences drain.
module recirculador_multilane
    import recirc_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk_2f,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] data_input,
    input  logic [LANES-1:0]       valid,
    input  logic                   data_and_active,
    input  logic                   active_ready,
    output logic [LANES*WIDTH-1:0] data_recirculador_active,
    output logic [LANES-1:0]       valid_active,
    output logic [LANES*WIDTH-1:0] data_recirculador_inactive,
    output logic [LANES-1:0]       valid_inactive,
    output logic [LANES-1:0]       fifo_full,
    output logic [LANES-1:0]       overflow,
    output logic [CNT_W-1:0]       recirc_count,
    output logic [STATE_W-1:0]     state
);

    localparam int PC_W  = clog2(LANES + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0] SUM_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

    logic [LANES-1:0]       push_s, pop_s, empty_s, empty_next_s, recirc_s;
    logic [LANES*WIDTH-1:0] inact_data_q, inact_data_d;
    logic [LANES-1:0]       inact_valid_q, inact_valid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PC_W-1:0]        pc_s;
    logic [SUM_W-1:0]       sum_s;
    state_e                 state_q, state_d;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        recirc_lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk        (clk_2f),
            .reset      (reset),
            .push       (push_s[g]),
            .pop        (pop_s[g]),
            .din        (data_input[g*WIDTH +: WIDTH]),
            .head       (data_recirculador_active[g*WIDTH +: WIDTH]),
            .empty      (empty_s[g]),
            .full       (fifo_full[g]),
            .empty_next (empty_next_s[g]),
            .overflow   (overflow[g])
        );
    end

    // Lane routing, recirculation registers and saturating word counter.
    always_comb begin
        valid_active  = ~empty_s;
        push_s        = valid & {LANES{data_and_active}};
        pop_s         = valid_active & {LANES{active_ready}};
        recirc_s      = valid & ~{LANES{data_and_active}};
        inact_valid_d = recirc_s;
        inact_data_d  = inact_data_q;
        pc_s          = {PC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (push_s[i]) begin
                inact_data_d[i*WIDTH +: WIDTH] = inact_data_q[i*WIDTH +: WIDTH];
            end else begin
                inact_data_d[i*WIDTH +: WIDTH] = data_input[i*WIDTH +: WIDTH];
            end
            if (recirc_s[i]) begin
                pc_s = pc_s + PC_ONE;
            end else begin
                pc_s = pc_s;
            end
        end
        sum_s = {{PC_W{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, pc_s};
        if (sum_s > SUM_MAX) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = sum_s[CNT_W-1:0];
        end
        data_recirculador_inactive = inact_data_q;
        valid_inactive             = inact_valid_q;
        recirc_count               = cnt_q;
    end

    // Recirculation path and counter registers.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            inact_data_q  <= {(LANES*WIDTH){1'b0}};
            inact_valid_q <= {LANES{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            inact_data_q  <= inact_data_d;
            inact_valid_q <= inact_valid_d;
            cnt_q         <= cnt_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a reasserted link takes priority over finishing a drain.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (data_and_active) state_d = ST_ACTIVE;
                else                 state_d = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (data_and_active)  state_d = ST_ACTIVE;
                else if (~&empty_s)   state_d = ST_DRAIN;
                else                  state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_and_active)     state_d = ST_ACTIVE;
                else if (&empty_next_s)  state_d = ST_IDLE;
                else                     state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        case (state_q)
            ST_IDLE:   state = 2'd0;
            ST_ACTIVE: state = 2'd1;
            ST_DRAIN:  state = 2'd2;
            default:   state = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_recirculador_multilane.sv
// Directed scoreboard bench: expected active/recirculated words are queued as
// stimulus is issued and checked by a negedge monitor as the DUT presents them.
module tb_recirculador_multilane;

    logic         clk_2f = 1'b0;
    logic         reset;
    logic [127:0] data_input;
    logic [3:0]   valid;
    logic         data_and_active;
    logic         active_ready;

    logic [127:0] d_act, d_inact, s_act, s_inact;
    logic [3:0]   v_act, v_inact, f_full, ovf, s_vact, s_vinact, s_full, s_ovf;
    logic [15:0]  cnt;
    logic [3:0]   s_cnt;
    logic [1:0]   st, s_st;

    logic [31:0]  act_q   [4][$];
    logic [31:0]  inact_q [4][$];
    int           exp_cnt, exp_sat;
    int           nvec = 0;
    int           nerr = 0;

    always #5 clk_2f = ~clk_2f;

    recirculador_multilane #(.LANES(4), .WIDTH(32), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk_2f(clk_2f), .reset(reset), .data_input(data_input), .valid(valid),
        .data_and_active(data_and_active), .active_ready(active_ready),
        .data_recirculador_active(d_act), .valid_active(v_act),
        .data_recirculador_inactive(d_inact), .valid_inactive(v_inact),
        .fifo_full(f_full), .overflow(ovf), .recirc_count(cnt), .state(st));

    recirculador_multilane #(.LANES(4), .WIDTH(32), .DEPTH(4), .CNT_W(4)) u_sat (
        .clk_2f(clk_2f), .reset(reset), .data_input(data_input), .valid(valid),
        .data_and_active(data_and_active), .active_ready(active_ready),
        .data_recirculador_active(s_act), .valid_active(s_vact),
        .data_recirculador_inactive(s_inact), .valid_inactive(s_vinact),
        .fifo_full(s_full), .overflow(s_ovf), .recirc_count(s_cnt), .state(s_st));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Apply one cycle of stimulus; queue expectations; return 1ns after the edge.
    task automatic drive(input logic r, input logic [3:0] v, input logic d, input logic rdy,
                         input logic [127:0] words, input logic [3:0] drop);
        reset = r; valid = v; data_and_active = d; active_ready = rdy; data_input = words;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                act_q[i].delete();
            end else begin
                if (v[i] && d && !drop[i]) act_q[i].push_back(words[i*32 +: 32]);
                if (v[i] && !d) begin
                    inact_q[i].push_back(words[i*32 +: 32]);
                    if (exp_cnt < 65535) exp_cnt++;
                    if (exp_sat < 15) exp_sat++;
                end
            end
        end
        if (r) begin
            exp_cnt = 0;
            exp_sat = 0;
        end
        @(posedge clk_2f);
        #1;
    endtask

    function automatic logic [127:0] lanes(input logic [31:0] base, input logic [31:0] step);
        logic [127:0] w;
        for (int i = 0; i < 4; i++) w[i*32 +: 32] = base + step * i;
        return w;
    endfunction

    // Monitor: pop and compare whenever a lane transfers or recirculates a word.
    always @(negedge clk_2f) begin
        for (int i = 0; i < 4; i++) begin
            if (v_act[i] && active_ready) begin
                if (act_q[i].size() == 0) check("act_unexpected", {96'd0, d_act[i*32 +: 32]}, 128'd0);
                else check("act_word", {96'd0, d_act[i*32 +: 32]}, {96'd0, act_q[i].pop_front()});
            end
            if (v_inact[i]) begin
                if (inact_q[i].size() == 0) check("inact_unexpected", {96'd0, d_inact[i*32 +: 32]}, 128'd0);
                else check("inact_word", {96'd0, d_inact[i*32 +: 32]}, {96'd0, inact_q[i].pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_cnt = 0; exp_sat = 0;
        reset = 1'b1; valid = 4'h0; data_and_active = 1'b0; active_ready = 1'b0; data_input = 128'd0;

        // Reset with traffic present.
        drive(1'b1, 4'hF, 1'b1, 1'b0, lanes(32'h11110000, 32'h1), 4'h0);
        drive(1'b1, 4'hF, 1'b1, 1'b0, lanes(32'h11110000, 32'h1), 4'h0);
        check("rst_valid_active", v_act, 4'h0);
        check("rst_valid_inactive", v_inact, 4'h0);
        check("rst_data_active", d_act, 128'd0);
        check("rst_data_inactive", d_inact, 128'd0);
        check("rst_full_ovf", {f_full, ovf}, 8'h00);
        check("rst_count", cnt, 16'd0);
        check("rst_state", st, 2'd0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 128'd0, 4'h0);
        check("idle_state", st, 2'd0);

        // Streaming: all lanes active, downstream always ready.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'hF, 1'b1, 1'b1, lanes(32'hA0000001 + k, 32'h01000000), 4'h0);
            if (k == 0) begin
                check("stream_latency_valid", v_act, 4'hF);
                check("stream_latency_data", d_act[31:0], 32'hA0000001);
                check("stream_state", st, 2'd1);
            end
        end
        for (int k = 0; k < 3; k++) drive(1'b0, 4'h0, 1'b0, 1'b1, 128'd0, 4'h0);
        check("stream_count", cnt, 16'd0);
        check("stream_end_state", st, 2'd0);

        // Overflow on lane 0: five pushes into a four-deep FIFO.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'h1, 1'b1, 1'b0, {96'd0, 32'hB0000001 + k}, (k == 4) ? 4'h1 : 4'h0);
            if (k == 3) check("ovf_full_after4", {f_full[0], ovf[0]}, 2'b10);
            if (k == 4) check("ovf_sticky_after5", {f_full[0], ovf[0]}, 2'b11);
        end
        for (int k = 0; k < 6; k++) drive(1'b0, 4'h0, 1'b0, 1'b1, 128'd0, 4'h0);
        check("ovf_drained", {v_act, f_full}, 8'h00);
        check("ovf_held", ovf, 4'h1);
        check("ovf_end_state", st, 2'd0);

        // Drain: three buffered words, link drops with downstream stalled.
        for (int k = 0; k < 3; k++) drive(1'b0, 4'h1, 1'b1, 1'b0, {96'd0, 32'hC0000001 + k}, 4'h0);
        drive(1'b0, 4'hF, 1'b0, 1'b0, lanes(32'hDEAD0000, 32'h1), 4'h0);
        check("drain_enter", st, 2'd2);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 128'd0, 4'h0);
        check("drain_stalled", st, 2'd2);
        drive(1'b0, 4'h0, 1'b0, 1'b1, 128'd0, 4'h0);
        check("drain_pop1", st, 2'd2);
        drive(1'b0, 4'h0, 1'b0, 1'b1, 128'd0, 4'h0);
        check("drain_pop2", st, 2'd2);
        drive(1'b0, 4'h0, 1'b0, 1'b1, 128'd0, 4'h0);
        check("drain_done", st, 2'd0);
        check("drain_count", cnt, 16'd4);

        // Link reasserts during DRAIN on lane 1.
        drive(1'b0, 4'h2, 1'b1, 1'b0, {64'd0, 32'hD0000001, 32'd0}, 4'h0);
        drive(1'b0, 4'h2, 1'b1, 1'b0, {64'd0, 32'hD0000002, 32'd0}, 4'h0);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 128'd0, 4'h0);
        check("reassert_drain", st, 2'd2);
        drive(1'b0, 4'h2, 1'b1, 1'b0, {64'd0, 32'hD0000003, 32'd0}, 4'h0);
        check("reassert_active", st, 2'd1);
        for (int k = 0; k < 5; k++) drive(1'b0, 4'h0, 1'b0, 1'b1, 128'd0, 4'h0);
        check("reassert_end", {2'b00, st, v_act}, 8'h00);

        // Counter saturation on the 4-bit instance.
        drive(1'b1, 4'h0, 1'b0, 1'b0, 128'd0, 4'h0);
        for (int k = 0; k < 5; k++) drive(1'b0, 4'hF, 1'b0, 1'b0, lanes(32'hE0000000 + 32'h10 * k, 32'h1), 4'h0);
        check("sat_count", s_cnt, 4'd15);
        check("wide_count", cnt, 16'd20);
        drive(1'b0, 4'hF, 1'b0, 1'b0, lanes(32'hE0000100, 32'h1), 4'h0);
        check("sat_hold", s_cnt, 4'd15);
        check("wide_count_model", cnt, exp_cnt[15:0]);

        // Reset mid-operation discards buffered words.
        drive(1'b0, 4'h4, 1'b1, 1'b0, {32'd0, 32'hF0000001, 64'd0}, 4'h0);
        drive(1'b0, 4'h4, 1'b1, 1'b0, {32'd0, 32'hF0000002, 64'd0}, 4'h0);
        check("midrst_buffered", v_act, 4'h4);
        drive(1'b1, 4'h0, 1'b0, 1'b0, 128'd0, 4'h0);
        check("midrst_cleared", {v_act, v_inact, f_full, ovf}, 16'h0000);
        check("midrst_state_cnt", {st, cnt}, 18'd0);
        drive(1'b0, 4'h0, 1'b0, 1'b1, 128'd0, 4'h0);
        drive(1'b0, 4'h0, 1'b0, 1'b1, 128'd0, 4'h0);
        check("midrst_no_valid", {v_act, d_act[95:64]}, 36'd0);

        for (int i = 0; i < 4; i++) begin
            check("act_queue_empty", act_q[i].size(), 0);
            check("inact_queue_empty", inact_q[i].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
